// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the MM:SS BCD countdown timer.
//   BCD_W            width of one BCD digit
//   BCD_MAX          largest legal BCD digit, also the borrow reload for
//                    sec_ones and every minute digit
//   SEC_TENS_RELOAD  reload value of sec_tens on borrow (x9 -> x5:9)
//   ADD_TENS         tens-of-seconds added by the quick-add key
//   bcd_add()        single-digit BCD add of 0..2 with carry out
package bcd_countdown_timer_pkg;

   localparam int               BCD_W           = 4;
   localparam logic [BCD_W-1:0] BCD_MAX         = 4'd9;
   localparam logic [BCD_W-1:0] SEC_TENS_RELOAD = 4'd5;
   localparam logic [BCD_W-1:0] ADD_TENS        = 4'd3;
   // sec_tens after adding ADD_TENS: at or above these, one or two minutes carry
   localparam logic [BCD_W-1:0] TENS_ONE_MIN    = 4'd6;
   localparam logic [BCD_W-1:0] TENS_TWO_MIN    = 4'd12;

   typedef enum logic [1:0] {
      MIN_INC_0 = 2'd0,
      MIN_INC_1 = 2'd1,
      MIN_INC_2 = 2'd2
   } min_inc_e;

   typedef struct packed {
      logic             carry;
      logic [BCD_W-1:0] digit;
   } bcd_sum_t;

   function automatic bcd_sum_t bcd_add(input logic [BCD_W-1:0] a,
                                        input logic [1:0]       inc);
      logic [BCD_W:0] raw;
      bcd_sum_t       r;
      raw = {1'b0, a} + {3'b000, inc};
      if (raw > {1'b0, BCD_MAX}) begin
         r.carry = 1'b1;
         // modulo-16 wrap of the low nibble gives raw-10 for raw 10..11
         r.digit = raw[BCD_W-1:0] - 4'd10;
      end else begin
         r.carry = 1'b0;
         r.digit = raw[BCD_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with parallel load.
//   clk, clear     clock and synchronous active-high clear (q -> 0)
//   load/load_val  parallel load, wins over dec
//   dec            decrement; at 0 the digit reloads reload_val
//   reload_val     value taken when decrementing from 0
//   q              current digit
//   borrow         q==0 && dec, decrements the next digit up
//   is_zero        q==0
module bcd_digit_down
   import bcd_countdown_timer_pkg::*;
(
   input  logic             clk,
   input  logic             clear,
   input  logic             load,
   input  logic [BCD_W-1:0] load_val,
   input  logic             dec,
   input  logic [BCD_W-1:0] reload_val,
   output logic [BCD_W-1:0] q,
   output logic             borrow,
   output logic             is_zero
);

   always_ff @(posedge clk) begin
      if (clear) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (dec) begin
         q <= is_zero ? reload_val : q - BCD_W'(1);
      end
   end

   assign is_zero = (q == '0);
   assign borrow  = is_zero && dec;

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer with keypad shift-in entry, +30 s quick-add,
// internal 1 s prescaler and a one-cycle done pulse.
//   clk         rising-edge clock
//   clear       synchronous active-high clear, overrides everything
//   en          1 = run, 0 = paused / editable
//   load_digit  strobe: shift data into sec_ones (only while paused, data<=9)
//   data        BCD keypad digit
//   add30       strobe: add 30 s, saturating at all-9 minutes :59
//   sec_ones    seconds units
//   sec_tens    seconds tens (may read 6..9 straight after keypad entry)
//   mins        minute digits, digit k at [4k+3:4k]
//   zero        every digit is 0
//   done        one-cycle pulse when a countdown tick reaches 00:00
//   running     en && !zero
module bcd_countdown_timer
   import bcd_countdown_timer_pkg::*;
#(
   parameter int MIN_DIGITS = 2,
   parameter int TICK_DIV   = 1
) (
   input  logic                        clk,
   input  logic                        clear,
   input  logic                        en,
   input  logic                        load_digit,
   input  logic [BCD_W-1:0]            data,
   input  logic                        add30,
   output logic [BCD_W-1:0]            sec_ones,
   output logic [BCD_W-1:0]            sec_tens,
   output logic [BCD_W*MIN_DIGITS-1:0] mins,
   output logic                        zero,
   output logic                        done,
   output logic                        running
);

   // digit index: 0 = sec_ones, 1 = sec_tens, 2.. = minutes LS first
   localparam int ND = MIN_DIGITS + 2;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

   logic [BCD_W-1:0] q        [ND];
   logic [BCD_W-1:0] load_val [ND];
   logic [ND-1:0]    is_zero;
   logic [PW-1:0]    presc;
   logic             accept_load;
   logic             add_now;
   logic             load_all;
   logic             advance;
   logic             tick;
   logic             last_sec;
   logic             msd_borrow_unused;
   logic [BCD_W-1:0] tens_sum;
   logic [1:0]       carry;
   min_inc_e         min_inc;
   bcd_sum_t         sum;

   assign zero        = &is_zero;
   assign running     = en && !zero;
   assign accept_load = load_digit && !en && (data <= BCD_MAX);
   assign add_now     = add30 && !accept_load;
   assign load_all    = accept_load || add_now;
   // any key strobe stalls the prescaler so an add30 landing on the tick
   // cycle defers the tick by one clock instead of losing it
   assign advance     = running && !add30 && !load_digit;
   assign tick        = advance && (presc == '0);
   assign last_sec    = (q[0] == BCD_W'(1)) && (&is_zero[ND-1:1]);

   // Prescaler counts down TICK_DIV-1..0; phase-equivalent to an up-count
   // that ticks on TICK_DIV-1, so a fresh start gives its first tick after
   // TICK_DIV running cycles.
   always_ff @(posedge clk) begin
      if (clear) begin
         presc <= PRESC_TOP;
         done  <= 1'b0;
      end else begin
         if (accept_load) begin
            presc <= PRESC_TOP;
         end else if (advance) begin
            presc <= (presc == '0) ? PRESC_TOP : presc - PW'(1);
         end
         done <= tick && last_sec;
      end
   end

   always_comb begin
      for (int i = 0; i < ND; i++) begin
         load_val[i] = q[i];
      end
      tens_sum = q[1] + ADD_TENS;
      min_inc  = MIN_INC_0;
      carry    = 2'd0;
      sum      = '0;
      if (accept_load) begin
         load_val[0] = data;
         for (int i = 1; i < ND; i++) begin
            load_val[i] = q[i-1];
         end
      end else begin
         if (tens_sum >= TENS_TWO_MIN) begin
            load_val[1] = tens_sum - TENS_TWO_MIN;
            min_inc     = MIN_INC_2;
         end else if (tens_sum >= TENS_ONE_MIN) begin
            load_val[1] = tens_sum - TENS_ONE_MIN;
            min_inc     = MIN_INC_1;
         end else begin
            load_val[1] = tens_sum;
         end
         carry = min_inc;
         for (int k = 0; k < MIN_DIGITS; k++) begin
            sum           = bcd_add(q[k+2], carry);
            load_val[k+2] = sum.digit;
            carry         = {1'b0, sum.carry};
         end
         if (carry != 2'd0) begin
            for (int k = 0; k < MIN_DIGITS; k++) begin
               load_val[k+2] = BCD_MAX;
            end
            load_val[1] = SEC_TENS_RELOAD;
            load_val[0] = BCD_MAX;
         end
      end
   end

   for (genvar i = 0; i < ND; i++) begin : g_dig
      logic dec_i;
      logic borrow_i;
      if (i == 0) begin : g_ls
         assign dec_i = tick;
      end else begin : g_up
         assign dec_i = g_dig[i-1].borrow_i;
      end
      bcd_digit_down u_digit (
         .clk        (clk),
         .clear      (clear),
         .load       (load_all),
         .load_val   (load_val[i]),
         .dec        (dec_i),
         .reload_val ((i == 1) ? SEC_TENS_RELOAD : BCD_MAX),
         .q          (q[i]),
         .borrow     (borrow_i),
         .is_zero    (is_zero[i])
      );
   end

   // ticks only occur while nonzero, so the top digit never borrows
   assign msd_borrow_unused = g_dig[ND-1].borrow_i;

   assign sec_ones = q[0];
   assign sec_tens = q[1];
   for (genvar k = 0; k < MIN_DIGITS; k++) begin : g_mins
      assign mins[BCD_W*k +: BCD_W] = q[k+2];
   end

endmodule
